symbol_mapper: RTL
==================

SYMBOL_MAPPER -- requirements
Module: symbol_mapper

Interface
REQ-001 SHALL have parameter SYMB_PERIOD, default 3: clock cycles between symbol strobes (legal range 2..15).
REQ-002 SHALL have parameter AMP, default 16'sh16A1 (+5793): BPSK amplitude in signed two's complement.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: depth of the input byte FIFO, in bytes (power of two).
REQ-004 Port: clk  input  1  the single clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: data_in  input  8  byte to transmit, MSB sent first.
REQ-007 Port: data_valid  input  1  data_in is valid this cycle.
REQ-008 Port: data_ready  output  1  FIFO can accept a byte; equals not-full.
REQ-009 Port: symb_out  output  16  signed symbol to the transmitter; held between strobes.
REQ-010 Port: read  output  1  one-cycle strobe marking a new symb_out value for the transmitter.
REQ-011 Port: busy  output  1  high while state is not IDLE.

Function
REQ-012 A byte SHALL be written to the FIFO on an edge where data_valid and data_ready are both high; data_valid is ignored while data_ready is low.
REQ-013 A pacing counter SHALL count 0..SYMB_PERIOD-1 and wrap to 0. read SHALL be registered high for exactly one cycle on each edge where the counter is 0.
REQ-014 symb_out SHALL update only on read edges. Between strobes it SHALL hold its value.
REQ-015 Mapping SHALL be: bit 1 -> +AMP (0x16A1); bit 0 -> -AMP (0xE95F); idle -> 0x0000.
REQ-016 The state machine SHALL have the states IDLE, PREAMBLE (present only with PREAMBLE_EN), and SHIFT.
REQ-017 In IDLE at a strobe edge:
- If the FIFO is empty: emit 0 and stay in IDLE.
- If the FIFO is non-empty and PREAMBLE_EN is off: pop one byte into the shift register, emit its bit 7 in the same strobe, and go to SHIFT with the bit count at 1.
REQ-018 In SHIFT, each strobe SHALL emit the next bit, MSB first. After the 8th bit of a byte, the next strobe SHALL behave as follows:
- If the FIFO is non-empty: pop the next byte and emit its bit 7, with no gap symbol.
- Otherwise: emit 0 and return to IDLE.
REQ-019 FIFO status at a strobe edge SHALL be the registered status before that edge. A byte written on the same edge is not visible until the next strobe.
REQ-020 A write and a pop on the same edge SHALL both take effect; the occupancy count stays unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Writes SHALL never overwrite unread data, and pops SHALL never occur when the FIFO is empty.

Reset
REQ-022 While reset is high, the following SHALL hold asynchronously:
- symb_out = 0, read = 0, busy = 0
- pacing counter = 0, state = IDLE
- FIFO empty, so data_ready = 1
- shift register and bit count cleared
REQ-023 The first strobe SHALL occur on the first rising edge after reset deasserts.
REQ-024 Reset asserted mid-byte SHALL discard the partial byte and all FIFO contents. No stale symbol may appear after release.

Configuration
REQ-025 Macro SYMBOL_MAPPER_PREAMBLE_EN: when defined, an IDLE strobe with a non-empty FIFO SHALL behave as follows:
- Enter PREAMBLE and emit 8 alternating symbols, starting +AMP (+,-,+,-,+,-,+,-).
- Then pop the first byte at the next strobe, continuing as in SHIFT.
- Back-to-back bytes within one burst SHALL receive no further preamble.
REQ-026 When the macro is undefined, the PREAMBLE state and its counter SHALL be absent, and behaviour SHALL follow REQ-017.

Verification
REQ-027 Reset for 1 cycle, no data -> read pulses every 3 cycles starting on the first edge after release; symb_out = 0x0000; busy = 0.
REQ-028 Write 0xA5 while idle -> the next 8 strobes give 16A1, E95F, 16A1, E95F, E95F, 16A1, E95F, 16A1; then 0x0000 and busy = 0.
REQ-029 data_valid held high with 6 bytes queued -> data_ready drops at 4 stored bytes; it recovers after each pop; 48 contiguous data symbols with no 0x0000 gap.
REQ-030 Assert reset on the 5th symbol of a byte with 2 bytes queued -> read = 0, symb_out = 0, data_ready = 1 immediately; after release, only 0x0000 symbols.
REQ-031 With SYMBOL_MAPPER_PREAMBLE_EN, write 0xFF -> 16A1, E95F ×4 pairs, then 8 × 0x16A1, then 0x0000.
REQ-032 Write on the same edge as a strobe with the FIFO empty -> that strobe emits 0x0000; the byte's bit 7 appears at the following strobe.

Source files
------------

// File: rtl/symbol_mapper.sv
// symbol_mapper: BPSK symbol mapper fed from a small byte FIFO.
//
// Bytes written through data_in/data_valid/data_ready are queued in a FIFO
// and sent MSB first, one bit per symbol strobe. Every SYMB_PERIOD clocks a
// strobe (read) marks a new symb_out value: bit 1 -> +AMP, bit 0 -> -AMP,
// nothing to send -> 0. Back-to-back bytes are sent with no gap symbol.
//
// Optional feature: define SYMBOL_MAPPER_PREAMBLE_EN to send 8 alternating
// preamble symbols (+,-,+,-,...) before the first byte of every burst.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   [7:0] byte to transmit
//   data_valid in   data_in valid this cycle
//   data_ready out  FIFO not full
//   symb_out   out  [15:0] signed symbol, held between strobes
//   read       out  one-cycle strobe marking a new symb_out
//   busy       out  state machine not idle
module symbol_mapper #(
    parameter int                 SYMB_PERIOD = 3,
    parameter logic signed [15:0] AMP         = 16'sh16A1,
    parameter int                 FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] symb_out,
    output logic        read,
    output logic        busy
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [15:0]      SYM_POS   = AMP;
    localparam logic [15:0]      SYM_NEG   = -AMP;
    localparam logic [15:0]      SYM_IDLE  = 16'h0000;
    localparam logic [3:0]       PACE_LAST = 4'(SYMB_PERIOD - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

`ifdef SYMBOL_MAPPER_PREAMBLE_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_PREAMBLE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    // Bit-to-symbol mapping.
    function automatic logic [15:0] map_bit(input logic b);
        return b ? SYM_POS : SYM_NEG;
    endfunction

    logic [3:0]       pace_cnt_r;
    logic             strobe_s;
    logic             read_r;
    logic [15:0]      symb_r;
    logic [15:0]      symb_next_s;
    logic             busy_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [7:0]       shreg_r;
    logic [7:0]       shreg_next_s;
    logic [3:0]       bit_cnt_r;
    logic [3:0]       bit_cnt_next_s;
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
    logic [3:0]       pre_cnt_r;
    logic [3:0]       pre_cnt_next_s;
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_r;
    logic             fifo_empty_s;
    logic             wr_en_s;
    logic             pop_s;
    logic [7:0]       head_s;

    assign strobe_s     = (pace_cnt_r == 4'd0);
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign wr_en_s      = data_valid & ~full_r;
    assign head_s       = mem_r[rd_ptr_r];

    assign data_ready = ~full_r;
    assign symb_out   = symb_r;
    assign read       = read_r;
    assign busy       = busy_r;

    // Symbol sequencing: all decisions use the FIFO status registered before the strobe edge.
    always_comb begin
        state_next_s   = state_r;
        shreg_next_s   = shreg_r;
        bit_cnt_next_s = bit_cnt_r;
        symb_next_s    = symb_r;
        pop_s          = 1'b0;
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
        pre_cnt_next_s = pre_cnt_r;
`endif
        if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (fifo_empty_s) begin
                        symb_next_s = SYM_IDLE;
                    end else begin
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
                        // First preamble symbol goes out on this strobe.
                        state_next_s   = ST_PREAMBLE;
                        pre_cnt_next_s = 4'd1;
                        symb_next_s    = SYM_POS;
`else
                        pop_s          = 1'b1;
                        shreg_next_s   = {head_s[6:0], 1'b0};
                        bit_cnt_next_s = 4'd1;
                        symb_next_s    = map_bit(head_s[7]);
                        state_next_s   = ST_SHIFT;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_r != 4'd8) begin
                        symb_next_s    = map_bit(shreg_r[7]);
                        shreg_next_s   = {shreg_r[6:0], 1'b0};
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                    end else if (!fifo_empty_s) begin
                        // Next byte follows without a gap symbol.
                        pop_s          = 1'b1;
                        shreg_next_s   = {head_s[6:0], 1'b0};
                        bit_cnt_next_s = 4'd1;
                        symb_next_s    = map_bit(head_s[7]);
                    end else begin
                        symb_next_s    = SYM_IDLE;
                        state_next_s   = ST_IDLE;
                        shreg_next_s   = 8'h00;
                        bit_cnt_next_s = 4'd0;
                    end
                end
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
                ST_PREAMBLE: begin
                    if (pre_cnt_r != 4'd8) begin
                        // Odd positions carry -AMP, even positions +AMP.
                        symb_next_s    = pre_cnt_r[0] ? SYM_NEG : SYM_POS;
                        pre_cnt_next_s = pre_cnt_r + 4'd1;
                    end else if (!fifo_empty_s) begin
                        pop_s          = 1'b1;
                        shreg_next_s   = {head_s[6:0], 1'b0};
                        bit_cnt_next_s = 4'd1;
                        symb_next_s    = map_bit(head_s[7]);
                        state_next_s   = ST_SHIFT;
                        pre_cnt_next_s = 4'd0;
                    end else begin
                        symb_next_s    = SYM_IDLE;
                        state_next_s   = ST_IDLE;
                        pre_cnt_next_s = 4'd0;
                    end
                end
`endif
                default: begin
                    symb_next_s    = SYM_IDLE;
                    state_next_s   = ST_IDLE;
                    shreg_next_s   = 8'h00;
                    bit_cnt_next_s = 4'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FIFO occupancy: simultaneous write and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pacing counter and read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pace_cnt_r <= 4'd0;
            read_r     <= 1'b0;
        end else begin
            pace_cnt_r <= (pace_cnt_r == PACE_LAST) ? 4'd0 : pace_cnt_r + 4'd1;
            read_r     <= strobe_s;
        end
    end

    // State machine, shift register and output symbol registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shreg_r   <= 8'h00;
            bit_cnt_r <= 4'd0;
            symb_r    <= SYM_IDLE;
            busy_r    <= 1'b0;
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
            pre_cnt_r <= 4'd0;
`endif
        end else begin
            state_r   <= state_next_s;
            shreg_r   <= shreg_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            symb_r    <= symb_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
`ifdef SYMBOL_MAPPER_PREAMBLE_EN
            pre_cnt_r <= pre_cnt_next_s;
`endif
        end
    end

    // FIFO pointers, count and full flag; reset drops all queued bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FIFO_FULL);
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

endmodule
